// File: rtl/mem_rr_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous RAM between NREQ requesters.
// Optional MEM_ARB_PRIO0_EN: requester 0 gets strict priority over the round-robin group.
module mem_rr_arbiter #(
  parameter int NREQ   = 2,
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_q
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0]   req_addr  [NREQ];
  logic [DW-1:0]   req_wdata [NREQ];

  logic [NREQ-1:0] gnt_reg;
  logic [IW-1:0]   gnt_id_reg;
  logic [IW-1:0]   ptr_reg;
  logic            mem_en_reg;
  logic            mem_we_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic [DW-1:0]   mem_wdata_reg;

  logic            pipe_valid_reg [RD_LAT];
  logic [IW-1:0]   pipe_id_reg    [RD_LAT];
  logic [NREQ-1:0] rd_valid_reg;
  logic [DW-1:0]   rd_data_reg;

  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [NREQ-1:0] win_onehot;
  logic            ptr_update;
  logic [NREQ-1:0] rd_valid_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_addr[gi]  = addr[gi*AW +: AW];
      assign req_wdata[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  // The requester granted last cycle still shows its completed access on req, so mask it.
  assign eligible = req & ~gnt_reg;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = ptr_reg;
    idx       = 0;
`ifdef MEM_ARB_PRIO0_EN
    if (eligible[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
`ifdef MEM_ARB_PRIO0_EN
      if (!win_found && (idx != 0) && eligible[IW'(idx)]) begin
`else
      if (!win_found && eligible[IW'(idx)]) begin
`endif
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

`ifdef MEM_ARB_PRIO0_EN
  // Requester 0 sits outside the rotation, so its grants leave the pointer alone.
  assign ptr_update = win_found && (win_id != '0);
`else
  assign ptr_update = win_found;
`endif

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_decode
      assign win_onehot[gi]    = win_found && (win_id == IW'(gi));
      assign rd_valid_next[gi] = pipe_valid_reg[RD_LAT-1] && (pipe_id_reg[RD_LAT-1] == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg       <= '0;
      gnt_id_reg    <= '0;
      ptr_reg       <= IW'(NREQ - 1);
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      gnt_reg    <= win_onehot;
      mem_en_reg <= win_found;
      mem_we_reg <= win_found & we[win_id];
      if (win_found) begin
        gnt_id_reg    <= win_id;
        mem_addr_reg  <= req_addr[win_id];
        mem_wdata_reg <= req_wdata[win_id];
      end
      if (ptr_update) ptr_reg <= win_id;
    end
  end

  // Read tags travel alongside the RAM latency so the result lands on the right requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_valid_reg[s] <= 1'b0;
        pipe_id_reg[s]    <= '0;
      end
      rd_valid_reg <= '0;
      rd_data_reg  <= '0;
    end else begin
      pipe_valid_reg[0] <= mem_en_reg & ~mem_we_reg;
      pipe_id_reg[0]    <= gnt_id_reg;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_valid_reg[s] <= pipe_valid_reg[s-1];
        pipe_id_reg[s]    <= pipe_id_reg[s-1];
      end
      rd_valid_reg <= rd_valid_next;
      if (pipe_valid_reg[RD_LAT-1]) rd_data_reg <= mem_q;
    end
  end

  assign gnt       = gnt_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: queue-driven requesters, a RAM model with RD_LAT latency,
// and a reference arbiter/memory model built from the grant and read-return rules.
module tb_mem_rr_arbiter;
  localparam int NREQ   = 2;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, we, gnt, rd_valid;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [DW-1:0]        rd_data, mem_wdata, mem_q;
  logic                 mem_en, mem_we;
  logic [AW-1:0]        mem_addr;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_q(mem_q)
  );

  // Single-port RAM with RD_LAT cycles from the enable cycle to valid q.
  logic [DW-1:0] ram    [2**AW];
  logic [DW-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        q_pipe[0]     <= ram[mem_addr];
    end
    for (int s = 1; s < RD_LAT; s++) q_pipe[s] <= q_pipe[s-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } acc_t;
  typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;

  acc_t          pend [NREQ][$];
  rd_t           rd_q [$];
  logic [DW-1:0] model_mem [2**AW];
  int            m_last  = -1;
  int            m_ptr   = NREQ - 1;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  int            cyc     = 0;

  function automatic acc_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_t r;
    r.w = w; r.a = a; r.d = d;
    return r;
  endfunction

  // Candidates listed in the order they come up after the pointer; last grantee is masked.
  function automatic int pick(input logic [NREQ-1:0] r);
    int cand[$];
    for (int k = 1; k <= NREQ; k++) begin
      int id;
      id = (m_ptr + k) % NREQ;
      if (r[id] && id != m_last) cand.push_back(id);
    end
`ifdef MEM_ARB_PRIO0_EN
    foreach (cand[j]) if (cand[j] == 0) return 0;
`endif
    if (cand.size() == 0) return -1;
    return cand[0];
  endfunction

  task automatic model_reset();
    m_last = -1; m_ptr = NREQ - 1; m_addr = '0; m_wdata = '0;
    rd_q.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0) begin
        req[i] = 1'b1;
        we[i]  = pend[i][0].w;
        addr[i*AW +: AW]  = pend[i][0].a;
        wdata[i*DW +: DW] = pend[i][0].d;
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  function automatic logic busy();
    for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    int w;
    logic [NREQ-1:0] eg, erv;
    logic ewe;
    rd_t e;
    w = pick(req);
    eg = '0; ewe = 1'b0;
    if (w >= 0) begin
      eg = NREQ'(1 << w);
      ewe = we[w];
      m_addr  = addr[w*AW +: AW];
      m_wdata = wdata[w*DW +: DW];
`ifdef MEM_ARB_PRIO0_EN
      if (w != 0) m_ptr = w;
`else
      m_ptr = w;
`endif
    end
    @(posedge clk); #1;
    cyc++;
    check("gnt", 64'(gnt), 64'(eg));
    check("mem_en", 64'(mem_en), 64'(w >= 0));
    check("mem_we", 64'(mem_we), 64'(ewe));
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    if (w >= 0) begin
      if (ewe) model_mem[m_addr] = m_wdata;
      else begin
        e.due = cyc + RD_LAT + 1; e.id = w; e.data = model_mem[m_addr];
        rd_q.push_back(e);
      end
    end
    erv = '0;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      erv = NREQ'(1 << e.id);
      check("rd_data", 64'(rd_data), 64'(e.data));
    end
    check("rd_valid", 64'(rd_valid), 64'(erv));
    $display("cyc %0d req=%b gnt=%b mem_en=%b we=%b addr=%h wd=%h rd_valid=%b rd_data=%h",
             cyc, req, gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data);
    m_last = w;
  endtask

  task automatic post();
    for (int i = 0; i < NREQ; i++)
      if (m_last == i && pend[i].size() > 0) pend[i].delete(0);
    drive();
  endtask

  task automatic run_idle(input int limit);
    int n;
    n = 0;
    drive();
    while (busy() && n < limit) begin step(); post(); n++; end
    check("idle_timeout", 64'(busy()), 64'(0));
    repeat (RD_LAT + 2) begin step(); post(); end
  endtask

  initial begin
    logic [NREQ-1:0] tbl [4];
    tbl[0] = NREQ'(1); tbl[1] = NREQ'(2); tbl[2] = NREQ'(1); tbl[3] = NREQ'(2);
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    @(negedge clk) rst = 1'b0;

    // Contention straight out of reset: requester 0 first, then strict alternation.
    for (int k = 0; k < 4; k++) begin
      pend[0].push_back(mk(1'b1, AW'(8'h20 + k), DW'($urandom)));
      pend[1].push_back(mk(1'b1, AW'(8'h40 + k), DW'($urandom)));
    end
    drive();
    for (int k = 0; k < 4; k++) begin
      step();
      check("cont_gnt", 64'(gnt), 64'(tbl[k]));
      post();
    end
    run_idle(20);

    // Fill the address window used by the random phase.
    for (int a = 0; a < 16; a++) pend[a % NREQ].push_back(mk(1'b1, AW'(a), DW'($urandom)));
    run_idle(60);

    pend[0].push_back(mk(1'b1, 8'h10, 16'h1111));
    pend[0].push_back(mk(1'b1, 8'h11, 16'h2222));
    run_idle(10);

    pend[1].push_back(mk(1'b1, 8'h30, 16'h7777));
    run_idle(10);
    pend[0].push_back(mk(1'b0, 8'h10, 16'h0));
    pend[1].push_back(mk(1'b0, 8'h30, 16'h0));
    run_idle(10);

    pend[1].push_back(mk(1'b1, 8'h55, 16'hABCD));
    pend[1].push_back(mk(1'b0, 8'h55, 16'h0));
    run_idle(10);

    drive();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (pend[i].size() < 2 && $urandom_range(0, 2) == 0)
          pend[i].push_back(mk(1'(($urandom_range(0, 1))), AW'($urandom_range(0, 15)), DW'($urandom)));
      step();
      post();
      for (int i = 0; i < NREQ; i++)
        if (req[i] && m_last != i && $urandom_range(0, 9) == 0) req[i] = 1'b0;
    end
    run_idle(40);

    // Reads in flight, then an asynchronous reset in mid-cycle with both requesting.
    pend[0].push_back(mk(1'b0, 8'h10, 16'h0));
    pend[1].push_back(mk(1'b0, 8'h30, 16'h0));
    drive();
    step(); post();
    step(); post();
    for (int i = 0; i < NREQ; i++) pend[i].push_back(mk(1'b1, AW'(8'h60 + i), DW'($urandom)));
    drive();
    #2 rst = 1'b1;
    #1;
    check("arst_gnt", 64'(gnt), 64'(0));
    check("arst_mem_en", 64'(mem_en), 64'(0));
    check("arst_mem_we", 64'(mem_we), 64'(0));
    check("arst_mem_addr", 64'(mem_addr), 64'(0));
    check("arst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("arst_rd_valid", 64'(rd_valid), 64'(0));
    check("arst_rd_data", 64'(rd_data), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    check("post_rst_first_gnt", 64'(gnt), 64'(1));
    post();
    run_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one single-port synchronous memory (Altera RAM wrapper) between NREQ requesters, e.g. SPI-side and MIL-side ring buffer engines.
- Registers the winning request onto the memory bus, returns read data with a per-requester valid strobe after the fixed memory read latency.
- Sits between the ring-buffer controllers and the memory wrapper.

Parameters:
NREQ, 2, number of requesters (2..4)
AW, 8, memory address width
DW, 16, memory data width
RD_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_q (1..4)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
req  in  NREQ  per-requester access request, held until granted
we  in  NREQ  per-requester write enable (1=write, 0=read)
addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
wdata  in  NREQ*DW  flattened write data, requester i at [i*DW +: DW]
gnt  out  NREQ  one-hot grant pulse, high in the cycle the access is on the memory bus
rd_valid  out  NREQ  one-hot pulse: rd_data holds read result for requester i
rd_data  out  DW  read data, common to all requesters
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_q  in  DW  memory read data, valid RD_LAT cycles after mem_en

Behaviour:
- Reset (async, rst=1): gnt, rd_valid, mem_en, mem_we = 0; mem_addr, mem_wdata, rd_data = 0; RR pointer = NREQ-1 (requester 0 first); tag pipeline cleared. Removal of reset synchronous to clk.
- Handshake: requester raises req with stable we/addr/wdata; keeps them until it samples gnt[i]=1 at a rising edge; may then drop req or present the next access.
- Arbitration at each edge: eligible = req & ~gnt (current granted requester masked, since its req still reflects the completed access). Winner = first eligible index after RR pointer, wrapping modulo NREQ.
- Next cycle (registered outputs): gnt[winner]=1, mem_en=1, mem_we/mem_addr/mem_wdata = winner's we/addr/wdata; RR pointer := winner. No eligible: gnt=0, mem_en=0, mem_we=0, mem_addr/mem_wdata hold.
- Latency: req sampled at edge k -> gnt/mem_en during cycle k+1 (minimum 1 cycle).
- Throughput: one access per cycle when ≥2 requesters active; a lone requester gets at most every other cycle (masking). Worst-case wait for any requester = NREQ grant cycles.
- Read return: RD_LAT-deep shift register of {valid, id}; entry loaded with {~mem_we & mem_en, winner} in grant cycle. At output: rd_valid[id]=1 for one cycle and rd_data := mem_q registered in that same cycle's capture, i.e. rd_valid/rd_data appear RD_LAT+1 cycles after gnt. Writes produce no rd_valid.
- Writes: memory write takes effect in gnt cycle; a read granted in the following cycle to the same address returns the new data (memory is read-after-write safe across cycles).
- req dropped without gnt: legal, request withdrawn, no access.
- Reset mid-operation: in-flight reads discarded, no rd_valid after reset release.
- gnt and rd_valid for different requesters may be high in the same cycle.

Optional Feature:
MEM_ARB_PRIO0_EN
- Defined: requester 0 has strict priority; if eligible it wins regardless of RR pointer; pointer not updated on a requester-0 grant; remaining requesters round-robin among themselves. Requester 0 (MIL receive path) never waits more than 1 arbitration cycle beyond its own masking cycle.
- Undefined: pure round-robin as above.

Test Plan:
- Reset: assert rst mid-cycle with req=2'b11 -> all outputs 0 immediately; after release, first gnt = 2'b01.
- Single writer: req[0] writes 16'h1111 to addr 8'h10, then 16'h2222 to 8'h11 -> gnt[0] pulses in alternate cycles, mem_we=1, mem_addr 8'h10 then 8'h11.
- Contention: both requesters hold req continuously (writes 8'h20.., 8'h40..) -> gnt alternates 01,10,01,10 every cycle, mem_en continuously 1.
- Read return: preload 8'h10=16'h1111, 8'h30=16'h7777; req[0] reads 8'h10, req[1] reads 8'h30 simultaneously -> rd_valid[0] with rd_data=16'h1111 RD_LAT+1 cycles after its gnt, then rd_valid[1] with 16'h7777 one cycle later.
- Write-then-read: requester 1 writes 16'hABCD to 8'h55, then reads 8'h55 -> rd_data=16'hABCD.
- With MEM_ARB_PRIO0_EN, NREQ=3, all req held -> gnt sequence 001,010,001,100,001,010 (requester 0 every other cycle, others rotating).
